load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the core's data bus: accepts one load/store request at a time from the execute stage. Routes each request to the memory port (mem_*) or the IO port (io_*) by address. Lane-aligns store data, extracts and extends load data, and reports misaligned or invalid accesses. Lives inside `core` and drives the same memory and IO signals that the top-level memory and IO responders decode.

## Interface
Parameters:
- IO_TAG, 4'hF: value of req_addr[31:28] that selects the IO port; any other value selects memory.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_sz  in  2  0 byte, 1 half, 2 word, 3 invalid
- req_signed  in  1  sign-extend load result
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  misaligned/invalid; valid with rsp_valid
- rsp_rdata  out  32  load result; valid with rsp_valid, 0 for stores/errors
- mem_r, mem_w  out  1  memory read/write strobe
- mem_sz  out  2  access size
- mem_addr  out  32  byte address
- mem_wdata  out  32  lane-aligned store data
- mem_rdata  in  32  word read data, valid the cycle after an accepted mem_r
- mem_busy  in  1  responder stall
- io_r, io_w  out  1  IO read/write strobe
- io_addr  out  16  req_addr[15:0]
- io_wdata  out  32  store data, unshifted
- io_rdata  in  32  combinational IO read data

## Operation
- Handshake: a request is accepted when req_valid && req_ready; req_ready = (state == IDLE).
- All request fields are registered at accept; bus outputs are driven only from registers.
- States: IDLE, ACCESS, RDATA, RESP.
- IDLE to ACCESS on accept of a legal request.
- IDLE to RESP on accept of an illegal request, with rsp_err = 1 and no bus strobe.
- ACCESS, memory: strobe asserted. While mem_busy = 1, stay in ACCESS with strobe, address, size and data held stable.
- ACCESS, memory, mem_busy = 0: load goes to RDATA; store goes to RESP.
- ACCESS, IO: a single-cycle strobe; mem_busy is ignored. io_rdata is captured in the same cycle, then go to RESP.
- RDATA: capture and format mem_rdata, then go to RESP.
- RESP: rsp_valid = 1 for one cycle, then go to IDLE.
- Illegal request: req_sz = 3; half with addr[0] = 1; word with addr[1:0] != 0; IO with req_sz != 2.
- Store lanes: mem_wdata = req_wdata << (8 * addr[1:0]). For bytes, bits outside the lane are don't-care but are driven as 0.
- Load format: shift mem_rdata right by 8 * addr[1:0], keep 8/16/32 bits, then zero- or sign-extend per req_signed. IO loads return io_rdata unmodified.
- Strobes are mutually exclusive; at most one of mem_r/mem_w/io_r/io_w is high in any cycle.
- Reset: async. State goes to IDLE; all outputs go to 0 (req_ready becomes 1 on the first cycle after release). An in-flight access is abandoned and no response is produced.

## Timing
- Accept in cycle T.
- Memory load: mem_r at T+1 if not busy; rsp_valid at T+3. Each busy cycle adds 1.
- Memory store: mem_w at T+1; rsp_valid at T+2. Each busy cycle adds 1.
- IO load/store: strobe at T+1; rsp_valid at T+2.
- Error: rsp_valid with rsp_err at T+1.
- Next accept is possible in the cycle after rsp_valid.
- rsp_valid, rsp_err and rsp_rdata are registered outputs.

## Structure
- lsu_pkg holds:
  - size enum SZ_B/SZ_H/SZ_W;
  - state enum;
  - IO_TAG default;
  - an io-address enum shared with the top level (IO_LED = 16'h1000).
- One combinational sub-module, lsu_load_fmt (word, offset, size, signed → result), reused by the bench model.

## Test plan
- Store word 0xDEADBEEF to 0x100, then load word from 0x100 → mem_w at T+1 with mem_wdata 0xDEADBEEF; rsp_rdata = 0xDEADBEEF at T+3.
- Store byte 0x80 to 0x102, then load byte signed and unsigned from 0x102 → mem_wdata = 0x00800000; results 0xFFFFFF80 and 0x00000080.
- Load half at 0x103 and word at 0x102 → rsp_err = 1 at T+1; no strobe is ever asserted.
- Word store 0x2A to 0xF0001000, then word load from 0xF0001000 → io_w with io_addr 0x1000; load returns 0x0000002A at T+2; an IO byte load returns rsp_err.
- Load with mem_busy held high for 3 cycles from T+1 → mem_r and mem_addr stable for 4 cycles; rsp_valid at T+6.
- Assert rst during ACCESS of a store → all strobes are 0 immediately; no rsp_valid; req_ready = 1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit and the IO decode at top level
package lsu_pkg;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_e;
  typedef enum logic [1:0] {IDLE, ACCESS, RDATA, RESP} state_e;
  localparam logic [3:0] IO_TAG_DEF = 4'hF;
  typedef enum logic [15:0] {IO_LED = 16'h1000} io_addr_e;
endpackage

// File: rtl/lsu_if.sv
// lsu_if: request/response handshake plus memory and IO bus signals of the load/store unit
interface lsu_if;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_sz;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_r, mem_w, mem_busy;
  logic [1:0]  mem_sz;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        io_r, io_w;
  logic [15:0] io_addr;
  logic [31:0] io_wdata, io_rdata;
  modport master (
    input  req_valid, req_we, req_signed, req_sz, req_addr, req_wdata, mem_busy, mem_rdata, io_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_r, mem_w, mem_sz, mem_addr, mem_wdata,
           io_r, io_w, io_addr, io_wdata
  );
  modport slave (
    output req_valid, req_we, req_signed, req_sz, req_addr, req_wdata, mem_busy, mem_rdata, io_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_r, mem_w, mem_sz, mem_addr, mem_wdata,
           io_r, io_w, io_addr, io_wdata
  );
endinterface

// File: rtl/lsu_load_fmt.sv
// lsu_load_fmt: pick the addressed byte/half/word out of a read word and zero- or sign-extend it
module lsu_load_fmt import lsu_pkg::*; (
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  sz,
  input  logic        sgn,
  output logic [31:0] result
);
  logic [31:0] sh;
  always_comb begin
    sh = word >> {off, 3'b000};
    result = sz == SZ_B ? {{24{sgn & sh[7]}}, sh[7:0]} :
             sz == SZ_H ? {{16{sgn & sh[15]}}, sh[15:0]} : sh;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time data bus initiator routing requests to the memory or IO port
module load_store_unit import lsu_pkg::*; #(
  parameter logic [3:0] IO_TAG = IO_TAG_DEF
) (
  input logic   clk,
  input logic   rst,
  lsu_if.master bus
);
  state_e      state, nxt;
  logic        accept, is_io, legal, we_q, sgn_q, io_q;
  logic [1:0]  sz_q;
  logic [31:0] addr_q, wdata_q, lane, fmt;
  assign accept = bus.req_valid && bus.req_ready;
  assign is_io = bus.req_addr[31:28] == IO_TAG;
  assign legal = !(bus.req_sz == 2'd3 || (bus.req_sz == SZ_H && bus.req_addr[0]) ||
                   (bus.req_sz == SZ_W && bus.req_addr[1:0] != 2'd0) || (is_io && bus.req_sz != SZ_W));
  assign lane = (bus.req_sz == SZ_B ? {24'd0, bus.req_wdata[7:0]} :
                 bus.req_sz == SZ_H ? {16'd0, bus.req_wdata[15:0]} : bus.req_wdata) << {bus.req_addr[1:0], 3'b000};
  assign bus.req_ready = state == IDLE && !rst;
  assign bus.mem_sz = sz_q;
  assign bus.mem_addr = addr_q;
  assign bus.io_addr = addr_q[15:0];
  assign bus.io_wdata = wdata_q;
  lsu_load_fmt u_fmt (.word(bus.mem_rdata), .off(addr_q[1:0]), .sz(sz_q), .sgn(sgn_q), .result(fmt));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = accept ? (legal ? ACCESS : RESP) : IDLE;
      ACCESS:  nxt = io_q ? RESP : bus.mem_busy ? ACCESS : we_q ? RESP : RDATA;
      RDATA:   nxt = RESP;
      default: nxt = IDLE;
    endcase
  end
  // Memory strobes hold through mem_busy; IO strobes are single-cycle.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {we_q, sgn_q, io_q, sz_q, addr_q, wdata_q} <= '0;
      {bus.mem_r, bus.mem_w, bus.io_r, bus.io_w, bus.mem_wdata} <= '0;
      {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} <= '0;
    end else begin
      bus.rsp_valid <= nxt == RESP;
      bus.mem_r <= (accept && legal && !is_io && !bus.req_we) || (bus.mem_r && bus.mem_busy);
      bus.mem_w <= (accept && legal && !is_io && bus.req_we) || (bus.mem_w && bus.mem_busy);
      bus.io_r <= accept && legal && is_io && !bus.req_we;
      bus.io_w <= accept && legal && is_io && bus.req_we;
      if (accept) begin
        we_q <= bus.req_we;
        sgn_q <= bus.req_signed;
        io_q <= is_io;
        sz_q <= bus.req_sz;
        addr_q <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        bus.mem_wdata <= lane;
        bus.rsp_err <= !legal;
        bus.rsp_rdata <= '0;
      end
      if (state == ACCESS && io_q && !we_q) bus.rsp_rdata <= bus.io_rdata;
      if (state == RDATA) bus.rsp_rdata <= fmt;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed requests with a response scoreboard, memory/IO responder models
module tb_load_store_unit;
  import lsu_pkg::*;
  typedef struct {logic err; logic [31:0] rd; int due;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, total = 0, passed = 0, bs = 1000000, bl = 0;
  int w_cyc = -1, iow_cyc = -1, r_cnt = 0, strobes = 0, c0 = 0, s0 = 0;
  logic [31:0] w_data = '0, iow_data = '0, r_addr = '0;
  logic [15:0] iow_addr = '0;
  logic [1:0] r_sz = '0;
  bit r_bad = 1'b0;
  bit [31:0] mem [256];
  logic [31:0] io_reg = '0, m;
  exp_t sb[$];
  exp_t e_m;
  lsu_if bus();
  load_store_unit #(.IO_TAG(4'hF)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign bus.io_rdata = bus.io_addr == IO_LED ? io_reg : 32'd0;
  always @(negedge clk) bus.mem_busy = cyc >= bs && cyc < bs + bl;
  always @(posedge clk) begin
    m = bus.mem_sz == SZ_B ? 32'hFF << {bus.mem_addr[1:0], 3'b000} :
        bus.mem_sz == SZ_H ? 32'hFFFF << {bus.mem_addr[1:0], 3'b000} : 32'hFFFF_FFFF;
    if (bus.mem_r && !bus.mem_busy) bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    if (bus.mem_w && !bus.mem_busy)
      mem[bus.mem_addr[9:2]] <= (mem[bus.mem_addr[9:2]] & ~m) | (bus.mem_wdata & m);
    if (bus.io_w && bus.io_addr == IO_LED) io_reg <= bus.io_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (bus.mem_r || bus.mem_w || bus.io_r || bus.io_w)
      chk("strobe_onehot", 32'($countones({bus.mem_r, bus.mem_w, bus.io_r, bus.io_w})), 1);
    strobes += $countones({bus.mem_r, bus.mem_w, bus.io_r, bus.io_w});
    if (bus.mem_w) begin w_cyc = cyc; w_data = bus.mem_wdata; end
    if (bus.io_w) begin iow_cyc = cyc; iow_addr = bus.io_addr; iow_data = bus.io_wdata; end
    if (bus.mem_r) begin
      r_cnt++;
      if (bus.mem_addr !== r_addr || bus.mem_sz !== r_sz) r_bad = 1'b1;
    end
    if (bus.rsp_valid) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_rsp: rsp_valid at cycle %0d with nothing outstanding", cyc);
      end else begin
        e_m = sb.pop_front();
        chk("rsp_err", 32'(bus.rsp_err), 32'(e_m.err));
        chk("rsp_rdata", bus.rsp_rdata, e_m.rd);
        chk("rsp_cycle", 32'(cyc), 32'(e_m.due));
      end
    end
  end

  task automatic xact(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                      input logic [31:0] wd, input logic ee, input logic [31:0] er, input int lat,
                      input int busy, output int t0);
    @(negedge clk);
    chk("req_ready", 32'(bus.req_ready), 1);
    t0 = cyc;
    bs = t0 + 1;
    bl = busy;
    sb.push_back('{ee, er, t0 + lat});
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_sz = sz; bus.req_signed = sg;
    bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      total++;
      $display("FAIL rsp_timeout: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_sz = 2'd0; bus.req_signed = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(bus.req_ready), 0);
    chk("reset_strobes", 32'({bus.mem_r, bus.mem_w, bus.io_r, bus.io_w}), 0);
    chk("reset_rsp", 32'({bus.rsp_valid, bus.rsp_err}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.req_ready), 1);
    chk("rdata_after_reset", bus.rsp_rdata, 0);
    // word store/load round trip
    xact(1, SZ_W, 0, 32'h100, 32'hDEAD_BEEF, 0, 0, 2, 0, c0);
    chk("sw_mem_w_cycle", 32'(w_cyc), 32'(c0 + 1));
    chk("sw_wdata", w_data, 32'hDEAD_BEEF);
    xact(0, SZ_W, 0, 32'h100, 0, 0, 32'hDEAD_BEEF, 3, 0, c0);
    // byte store into lane 2 with junk above the byte, then extending loads
    xact(1, SZ_B, 0, 32'h102, 32'hABCD_EF80, 0, 0, 2, 0, c0);
    chk("sb_mem_w_cycle", 32'(w_cyc), 32'(c0 + 1));
    chk("sb_wdata", w_data, 32'h0080_0000);
    xact(0, SZ_B, 1, 32'h102, 0, 0, 32'hFFFF_FF80, 3, 0, c0);
    xact(0, SZ_B, 0, 32'h102, 0, 0, 32'h0000_0080, 3, 0, c0);
    xact(0, SZ_H, 1, 32'h102, 0, 0, 32'hFFFF_DE80, 3, 0, c0);
    xact(0, SZ_H, 0, 32'h100, 0, 0, 32'h0000_BEEF, 3, 0, c0);
    // illegal requests: misaligned half/word and invalid size
    s0 = strobes;
    xact(0, SZ_H, 0, 32'h103, 0, 1, 0, 1, 0, c0);
    xact(0, SZ_W, 0, 32'h102, 0, 1, 0, 1, 0, c0);
    xact(1, 2'd3, 0, 32'h100, 32'h55, 1, 0, 1, 0, c0);
    chk("err_no_strobe", 32'(strobes - s0), 0);
    // IO port
    xact(1, SZ_W, 0, 32'hF000_1000, 32'h2A, 0, 0, 2, 0, c0);
    chk("io_w_cycle", 32'(iow_cyc), 32'(c0 + 1));
    chk("io_addr", 32'(iow_addr), 32'h1000);
    chk("io_wdata", iow_data, 32'h2A);
    xact(0, SZ_W, 0, 32'hF000_1000, 0, 0, 32'h2A, 2, 0, c0);
    s0 = strobes;
    xact(0, SZ_B, 0, 32'hF000_1000, 0, 1, 0, 1, 0, c0);
    chk("io_err_no_strobe", 32'(strobes - s0), 0);
    // memory load stalled by three busy cycles
    r_cnt = 0; r_addr = 32'h100; r_sz = SZ_W; r_bad = 1'b0;
    xact(0, SZ_W, 0, 32'h100, 0, 0, 32'hDE80_BEEF, 6, 3, c0);
    chk("busy_mem_r_cycles", 32'(r_cnt), 4);
    chk("busy_addr_stable", 32'(r_bad), 0);
    // reset while a store is on the bus
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_sz = SZ_W; bus.req_signed = 1'b0;
    bus.req_addr = 32'h200; bus.req_wdata = 32'h1122_3344;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_mem_w", 32'(bus.mem_w), 1);
    rst = 1'b1;
    #1;
    chk("rst_strobes_cleared", 32'({bus.mem_r, bus.mem_w, bus.io_r, bus.io_w}), 0);
    chk("rst_no_rsp", 32'(bus.rsp_valid), 0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_no_rsp", 32'(bus.rsp_valid), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.req_ready), 1);
    xact(0, SZ_W, 0, 32'h200, 0, 0, 32'h0, 3, 0, c0);
    xact(0, SZ_W, 0, 32'h100, 0, 0, 32'hDE80_BEEF, 3, 0, c0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
